foc_setpoint_gen: RTL and testbench
===================================

FOC_SETPOINT_GEN -- requirements
Module: foc_setpoint_gen

Interface
REQ-001 Parameter CH_CNT, default 2: number of setpoint channels (ch0 = d axis, ch1 = q axis).
REQ-002 Parameter WIDTH, default 16: signed setpoint width per channel.
REQ-003 Parameter PERIOD_W, default 24: width of the half-period tick counter.
REQ-004 Port clk, input, 1: the single clock, which is the FOC control clock.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port i_tick, input, 1: control-period pulse (en_idq); all waveform state advances only on it.
REQ-007 Port i_enable, input, 1: generator run enable.
REQ-008 Port i_mode, input, 2*CH_CNT: per-channel mode, 0 OFF, 1 CONST, 2 SQUARE, 3 TRIANGLE.
REQ-009 Port i_amp, input, WIDTH*CH_CNT: per-channel magnitude; the MSB is ignored, giving the range 0..2^(WIDTH-1)-1.
REQ-010 Port i_half_period, input, PERIOD_W: shared SQUARE half-period in ticks.
REQ-011 Port i_step, input, WIDTH-1: shared per-tick increment, used by TRIANGLE and by the slew limiter.
REQ-012 Port o_aim, output, WIDTH*CH_CNT: signed per-channel setpoints (id_aim, iq_aim, ...).
REQ-013 Port o_en, output, 1: one-cycle pulse that marks a new o_aim.
REQ-014 Port o_phase, output, 1: shared square phase, 0 = negative half, 1 = positive half.

Function
REQ-015 A tick is i_tick=1 in a clk cycle; o_aim and o_en shall update on the clk edge that follows the tick, giving 1-cycle latency.
REQ-016 o_en shall pulse for exactly one cycle per tick, regardless of i_enable or mode.
REQ-017 Square counter: on each tick the counter increments; when it equals max(i_half_period,1)-1 it wraps to 0 and o_phase toggles.
REQ-018 Channel target by mode: OFF gives 0; CONST gives +amp; SQUARE gives -amp while o_phase=0 and +amp while o_phase=1.
REQ-019 TRIANGLE: each tick the value moves by i_step in the direction flag, saturating at +/-amp; on reaching a bound the direction reverses for the next tick. The initial value is 0 and the initial direction is up.
REQ-020 An amp change that leaves the triangle value out of range shall clamp it to the new bound on the next tick.
REQ-021 With i_step=0 or amp=0, the triangle shall hold its current value.
REQ-022 Arithmetic shall use WIDTH+1 bits internally; no output shall ever wrap, and every result is saturated to +/-amp.
REQ-023 A mode change shall take effect on the next tick; the counter, phase and triangle state are not reset by it.
REQ-024 When i_enable=0, targets shall be 0, and the counter, o_phase, triangle value and direction shall reset on each tick.
REQ-025 Non-tick cycles shall hold all outputs except o_en, which is 0.

Reset
REQ-026 rst=1 shall force o_aim=0, o_en=0, o_phase=0, counter=0, triangle value 0 with direction up, and the slew register to 0.
REQ-027 rst shall take priority over a simultaneous tick; the first tick after rst is released shall behave as the first period.

Configuration
REQ-028 With macro FOC_SETPOINT_SLEW_EN defined, each o_aim channel shall move toward its target by at most i_step per tick.
REQ-029 Without FOC_SETPOINT_SLEW_EN, o_aim equals the target directly; i_step then affects only TRIANGLE, and the port stays present.

Structure
REQ-030 Mode encodings and the default widths shall live in the shared package foc_setpoint_pkg.
REQ-031 Per-channel target, triangle and slew logic shall be one sub-module, foc_setpoint_chan, instantiated CH_CNT times.
REQ-032 The half-period counter and phase shall be shared in the top level.

Verification
REQ-033 Reset then the first tick, with SQUARE, amp=200, half=3, enable=1 -> o_aim[q] = -200 for ticks 1-3 and +200 for ticks 4-6; o_phase toggles after tick 3; o_en pulses are 1 cycle wide, 1 cycle after each tick.
REQ-034 TRIANGLE, amp=10, step=4 -> values 4, 8, 10, 6, 2, -2, -6, -10, -6.
REQ-035 i_half_period=0, SQUARE, amp=5 -> polarity alternates every tick.
REQ-036 rst asserted together with a tick mid-square -> all outputs 0, no o_en; the next tick gives -amp.
REQ-037 With FOC_SETPOINT_SLEW_EN, SQUARE amp=100, step=30, at the phase flip from -100 -> -70, -40, -10, 20, 50, 80, 100; without the macro the flip is immediate.
REQ-038 CH_CNT=3, mixed modes OFF/CONST/TRIANGLE, amp=32767 -> channels are independent and never wrap; i_enable=0 -> all channels 0 on the next tick.

Source files
------------

// File: rtl/foc_setpoint_pkg.sv
// Shared mode encodings, triangle direction and default widths for the FOC setpoint generator.
package foc_setpoint_pkg;

  localparam int DEF_CH_CNT   = 2;
  localparam int DEF_WIDTH    = 16;
  localparam int DEF_PERIOD_W = 24;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_CONST  = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_TRI    = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/foc_setpoint_chan.sv
// One setpoint channel: mode target, triangle generator and optional slew limiter.
// Optional feature: FOC_SETPOINT_SLEW_EN enables the per-tick slew limit on aim.
module foc_setpoint_chan
  import foc_setpoint_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] amp,
  input  logic [WIDTH-2:0] step,
  input  logic             phase,
  output logic [WIDTH-1:0] aim
);

  localparam int EW = WIDTH + 1;

  mode_t                mode_e;
  dir_t                 dir_q, dir_d;
  logic signed [EW-1:0] amp_s, step_s, sum, tgt;
  logic signed [EW-1:0] tri_q, tri_d, aim_q, aim_d;
`ifdef FOC_SETPOINT_SLEW_EN
  logic signed [EW-1:0] diff;
`endif
  logic                 unused_bits;

  assign mode_e      = mode_t'(mode);
  assign amp_s       = $signed({2'b00, amp[WIDTH-2:0]});
  assign step_s      = $signed({2'b00, step});
  assign unused_bits = ^{amp[WIDTH-1], aim_q[WIDTH]};

  always_comb begin
    tri_d = tri_q;
    dir_d = dir_q;
    sum   = tri_q;
    tgt   = '0;
    if (!enable) begin
      tri_d = '0;
      dir_d = DIR_UP;
    end else begin
      if (mode_e == MODE_TRI) begin
        if (amp_s != '0 && step_s != '0)
          sum = (dir_q == DIR_UP) ? tri_q + step_s : tri_q - step_s;
        // Saturation also pulls a stale value back inside a reduced amp.
        if (sum >= amp_s) begin
          tri_d = amp_s;
          dir_d = DIR_DOWN;
        end else if (sum <= -amp_s) begin
          tri_d = -amp_s;
          dir_d = DIR_UP;
        end else begin
          tri_d = sum;
        end
      end
      case (mode_e)
        MODE_OFF:    tgt = '0;
        MODE_CONST:  tgt = amp_s;
        MODE_SQUARE: tgt = phase ? amp_s : -amp_s;
        MODE_TRI:    tgt = tri_d;
        default:     tgt = '0;
      endcase
    end
  end

`ifdef FOC_SETPOINT_SLEW_EN
  always_comb begin
    diff = tgt - aim_q;
    if (diff > step_s)
      aim_d = aim_q + step_s;
    else if (diff < -step_s)
      aim_d = aim_q - step_s;
    else
      aim_d = tgt;
  end
`else
  assign aim_d = tgt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      tri_q <= '0;
      dir_q <= DIR_UP;
      aim_q <= '0;
    end else if (tick) begin
      tri_q <= tri_d;
      dir_q <= dir_d;
      aim_q <= aim_d;
    end
  end

  assign aim = aim_q[WIDTH-1:0];

endmodule

// File: rtl/foc_setpoint_gen.sv
// FOC d/q setpoint generator: shared square half-period counter and phase, CH_CNT channels.
// Optional feature: FOC_SETPOINT_SLEW_EN (slew-limited outputs, handled in foc_setpoint_chan).
module foc_setpoint_gen
  import foc_setpoint_pkg::*;
#(
  parameter int CH_CNT   = DEF_CH_CNT,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PERIOD_W = DEF_PERIOD_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_tick,
  input  logic                    i_enable,
  input  logic [2*CH_CNT-1:0]     i_mode,
  input  logic [WIDTH*CH_CNT-1:0] i_amp,
  input  logic [PERIOD_W-1:0]     i_half_period,
  input  logic [WIDTH-2:0]        i_step,
  output logic [WIDTH*CH_CNT-1:0] o_aim,
  output logic                    o_en,
  output logic                    o_phase
);

  logic [PERIOD_W-1:0] cnt_q, wrap_at;
  logic                phase_q, en_q;

  // A half-period of 0 behaves as 1; >= keeps a shrunk period from running the counter out.
  assign wrap_at = (i_half_period == '0) ? '0 : i_half_period - PERIOD_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      en_q <= i_tick;
      if (i_tick) begin
        if (!i_enable) begin
          cnt_q   <= '0;
          phase_q <= 1'b0;
        end else if (cnt_q >= wrap_at) begin
          cnt_q   <= '0;
          phase_q <= ~phase_q;
        end else begin
          cnt_q <= cnt_q + PERIOD_W'(1);
        end
      end
    end
  end

  genvar c;
  generate
    for (c = 0; c < CH_CNT; c++) begin : g_ch
      foc_setpoint_chan #(
        .WIDTH(WIDTH)
      ) u_chan (
        .clk   (clk),
        .rst   (rst),
        .tick  (i_tick),
        .enable(i_enable),
        .mode  (i_mode[2*c +: 2]),
        .amp   (i_amp[WIDTH*c +: WIDTH]),
        .step  (i_step),
        .phase (phase_q),
        .aim   (o_aim[WIDTH*c +: WIDTH])
      );
    end
  endgenerate

  assign o_en    = en_q;
  assign o_phase = phase_q;

endmodule

// File: tb/tb_foc_setpoint_gen.sv
// Self-checking bench for foc_setpoint_gen: a 2-channel and a 3-channel instance against an integer model.
`timescale 1ns/1ps
module tb_foc_setpoint_gen;

  logic        clk = 1'b0;
  logic        rst, i_tick, i_enable;
  logic [3:0]  mode2;
  logic [31:0] amp2;
  logic [5:0]  mode3;
  logic [47:0] amp3;
  logic [23:0] i_half_period;
  logic [14:0] i_step;
  logic [31:0] o_aim2;
  logic [47:0] o_aim3;
  logic        o_en2, o_phase2, o_en3, o_phase3;

  int checks = 0;
  int failures = 0;

  // Model state: channels 0-1 belong to dut2, 2-4 to dut3; both share counter/phase inputs.
  int m_tri[5];
  int m_aim[5];
  bit m_up[5];
  int m_cnt;
  bit m_phase;

  foc_setpoint_gen #(.CH_CNT(2), .WIDTH(16), .PERIOD_W(24)) dut2 (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_enable(i_enable), .i_mode(mode2),
    .i_amp(amp2), .i_half_period(i_half_period), .i_step(i_step),
    .o_aim(o_aim2), .o_en(o_en2), .o_phase(o_phase2));

  foc_setpoint_gen #(.CH_CNT(3), .WIDTH(16), .PERIOD_W(24)) dut3 (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_enable(i_enable), .i_mode(mode3),
    .i_amp(amp3), .i_half_period(i_half_period), .i_step(i_step),
    .o_aim(o_aim3), .o_en(o_en3), .o_phase(o_phase3));

  always #5 clk = ~clk;

  function automatic int ch_mode(int k);
    return (k < 2) ? int'(mode2[2*k +: 2]) : int'(mode3[2*(k-2) +: 2]);
  endfunction

  function automatic int ch_amp(int k);
    return (k < 2) ? int'(amp2[16*k +: 15]) : int'(amp3[16*(k-2) +: 15]);
  endfunction

  function automatic logic [33:0] exp2(bit en);
    logic [33:0] v;
    v[33] = en;
    v[32] = m_phase;
    for (int k = 0; k < 2; k++) v[16*k +: 16] = 16'(m_aim[k]);
    return v;
  endfunction

  function automatic logic [49:0] exp3(bit en);
    logic [49:0] v;
    v[49] = en;
    v[48] = m_phase;
    for (int k = 0; k < 3; k++) v[16*k +: 16] = 16'(m_aim[k+2]);
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 5; k++) begin
      m_tri[k] = 0;
      m_aim[k] = 0;
      m_up[k]  = 1'b1;
    end
    m_cnt   = 0;
    m_phase = 1'b0;
  endtask

  task automatic model_tick();
    int a, s, md, tgt, nxt, hp;
`ifdef FOC_SETPOINT_SLEW_EN
    int d;
`endif
    s = int'(i_step);
    for (int k = 0; k < 5; k++) begin
      md  = ch_mode(k);
      a   = ch_amp(k);
      tgt = 0;
      if (!i_enable) begin
        m_tri[k] = 0;
        m_up[k]  = 1'b1;
      end else begin
        if (md == 3) begin
          if (a == 0 || s == 0) nxt = m_tri[k];
          else nxt = m_up[k] ? m_tri[k] + s : m_tri[k] - s;
          if (nxt >= a) begin
            m_tri[k] = a;
            m_up[k]  = 1'b0;
          end else if (nxt <= -a) begin
            m_tri[k] = -a;
            m_up[k]  = 1'b1;
          end else begin
            m_tri[k] = nxt;
          end
        end
        case (md)
          0:       tgt = 0;
          1:       tgt = a;
          2:       tgt = m_phase ? a : -a;
          default: tgt = m_tri[k];
        endcase
      end
`ifdef FOC_SETPOINT_SLEW_EN
      d = tgt - m_aim[k];
      if (d > s) m_aim[k] = m_aim[k] + s;
      else if (d < -s) m_aim[k] = m_aim[k] - s;
      else m_aim[k] = tgt;
`else
      m_aim[k] = tgt;
`endif
    end
    if (!i_enable) begin
      m_cnt   = 0;
      m_phase = 1'b0;
    end else begin
      hp = (i_half_period == 0) ? 1 : int'(i_half_period);
      if (m_cnt >= hp - 1) begin
        m_cnt   = 0;
        m_phase = ~m_phase;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    i_tick = 1'b1;
    model_tick();
    @(negedge clk);
    i_tick = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    i_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; i_tick = 1'b0; i_enable = 1'b1;
    mode2 = 4'hF; amp2 = '1; mode3 = '1; amp3 = '1;
    i_half_period = 24'd2; i_step = 15'd7;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_en2, o_phase2, o_aim2} !== 34'd0 || {o_en3, o_phase3, o_aim3} !== 50'd0) begin
      failures++;
      $display("FAIL reset got2=%h got3=%h want 0", {o_en2, o_phase2, o_aim2}, {o_en3, o_phase3, o_aim3});
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_square();
    int want;
    mode2 = {2'd2, 2'd0}; amp2 = {16'd200, 16'd0}; mode3 = '0; amp3 = '0;
    i_half_period = 24'd3; i_step = 15'd1000; i_enable = 1'b1;
    apply_reset();
    for (int t = 1; t <= 6; t++) begin
      pulse_tick();
      want = (t <= 3) ? -200 : 200;
      checks++;
      if ({o_en2, o_phase2, o_aim2} !== exp2(1'b1) || $signed(o_aim2[31:16]) !== want
          || o_phase2 !== ((t >= 3 && t < 6) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL square tick%0d got=%h want=%h iq_want=%0d", t, {o_en2, o_phase2, o_aim2}, exp2(1'b1), want);
      end
      @(negedge clk);
      checks++;
      if ({o_en2, o_phase2, o_aim2} !== exp2(1'b0)) begin
        failures++;
        $display("FAIL square_hold tick%0d got=%h want=%h", t, {o_en2, o_phase2, o_aim2}, exp2(1'b0));
      end
    end
  endtask

  task automatic test_triangle();
    int tv[9] = '{4, 8, 10, 6, 2, -2, -6, -10, -6};
    mode2 = {2'd3, 2'd3}; amp2 = {16'd10, 16'd10}; mode3 = '0;
    i_step = 15'd4; i_half_period = 24'd5; i_enable = 1'b1;
    apply_reset();
    for (int t = 0; t < 9; t++) begin
      pulse_tick();
      checks++;
      if ({o_en2, o_phase2, o_aim2} !== exp2(1'b1) || $signed(o_aim2[15:0]) !== tv[t]
          || $signed(o_aim2[31:16]) !== tv[t]) begin
        failures++;
        $display("FAIL triangle tick%0d got=%0d/%0d want=%0d", t, $signed(o_aim2[15:0]), $signed(o_aim2[31:16]), tv[t]);
      end
    end
  endtask

  task automatic test_half_zero();
    mode2 = {2'd2, 2'd2}; amp2 = {16'd5, 16'h8005}; i_half_period = '0;
    i_step = 15'd100; i_enable = 1'b1;
    apply_reset();
    for (int t = 0; t < 6; t++) begin
      pulse_tick();
      checks++;
      if ({o_en2, o_phase2, o_aim2} !== exp2(1'b1) || $signed(o_aim2[15:0]) !== ((t % 2 == 0) ? -5 : 5)) begin
        failures++;
        $display("FAIL half_zero tick%0d got=%h want=%h", t, {o_en2, o_phase2, o_aim2}, exp2(1'b1));
      end
    end
  endtask

  task automatic test_reset_mid();
    mode2 = {2'd2, 2'd1}; amp2 = {16'd50, 16'd9}; i_half_period = 24'd4;
    i_step = 15'd500; i_enable = 1'b1;
    apply_reset();
    repeat (5) pulse_tick();
    @(negedge clk);
    rst = 1'b1;
    i_tick = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_tick = 1'b0;
    model_reset();
    checks++;
    if ({o_en2, o_phase2, o_aim2} !== 34'd0) begin
      failures++;
      $display("FAIL reset_mid got=%h want=0", {o_en2, o_phase2, o_aim2});
    end
    pulse_tick();
    checks++;
    if ({o_en2, o_phase2, o_aim2} !== exp2(1'b1) || $signed(o_aim2[31:16]) !== -50) begin
      failures++;
      $display("FAIL reset_mid_first got=%h want=%h", {o_en2, o_phase2, o_aim2}, exp2(1'b1));
    end
  endtask

  task automatic test_slew_flip();
    mode2 = {2'd2, 2'd2}; amp2 = {16'd100, 16'd100}; i_half_period = 24'd9;
    i_step = 15'd30; i_enable = 1'b1;
    apply_reset();
    for (int t = 0; t < 24; t++) begin
      pulse_tick();
      checks++;
      if ({o_en2, o_phase2, o_aim2} !== exp2(1'b1)) begin
        failures++;
        $display("FAIL slew_flip tick%0d got=%h want=%h", t, {o_en2, o_phase2, o_aim2}, exp2(1'b1));
      end
    end
  endtask

  task automatic test_three_ch();
    mode2 = '0; mode3 = {2'd3, 2'd1, 2'd0}; amp3 = '1; i_half_period = 24'd2;
    i_enable = 1'b1;
    apply_reset();
    for (int t = 0; t < 16; t++) begin
      i_step = 15'($urandom_range(8192, 32767));
      pulse_tick();
      checks++;
      if ({o_en3, o_phase3, o_aim3} !== exp3(1'b1) || $signed(o_aim3[47:32]) === -16'sd32768) begin
        failures++;
        $display("FAIL three_ch tick%0d got=%h want=%h", t, {o_en3, o_phase3, o_aim3}, exp3(1'b1));
      end
    end
    i_enable = 1'b0;
    pulse_tick();
    checks++;
    if ({o_en3, o_phase3, o_aim3} !== {2'b10, 48'd0}) begin
      failures++;
      $display("FAIL three_ch_disable got=%h want=%h", {o_en3, o_phase3, o_aim3}, {2'b10, 48'd0});
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) apply_reset();
      if ($urandom_range(0, 3) == 0) begin
        mode2 = 4'($urandom);
        mode3 = 6'($urandom);
      end
      if ($urandom_range(0, 4) == 0) begin
        for (int k = 0; k < 2; k++)
          amp2[16*k +: 16] = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 300));
        for (int k = 0; k < 3; k++)
          amp3[16*k +: 16] = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 300));
      end
      if ($urandom_range(0, 5) == 0)
        i_step = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'($urandom_range(0, 60));
      if ($urandom_range(0, 9) == 0) i_half_period = 24'($urandom_range(0, 6));
      i_enable = ($urandom_range(0, 11) != 0);
      pulse_tick();
      checks++;
      if ({o_en2, o_phase2, o_aim2} !== exp2(1'b1) || {o_en3, o_phase3, o_aim3} !== exp3(1'b1)) begin
        failures++;
        $display("FAIL random n%0d got2=%h want2=%h got3=%h want3=%h", n,
                 {o_en2, o_phase2, o_aim2}, exp2(1'b1), {o_en3, o_phase3, o_aim3}, exp3(1'b1));
      end
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        checks++;
        if ({o_en2, o_phase2, o_aim2} !== exp2(1'b0) || {o_en3, o_phase3, o_aim3} !== exp3(1'b0)) begin
          failures++;
          $display("FAIL random_hold n%0d got2=%h want2=%h", n, {o_en2, o_phase2, o_aim2}, exp2(1'b0));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_triangle();
    test_half_zero();
    test_reset_mid();
    test_slew_flip();
    test_three_ch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
